// File: rtl/ras_predictor_v2_pkg.sv
// Shared helpers for the return address stack: event-delta width and the
// signed delta arithmetic used by the occupancy tracker.
package ras_predictor_v2_pkg;

    localparam int DeltaW = 3;

    // Net stack movement for one cycle; always lies in -2..+2, so three bits suffice.
    function automatic logic [DeltaW-1:0] eventDelta(
        input logic pushE,
        input logic incRep,
        input logic popF,
        input logic decRep
    );
        return DeltaW'(pushE) + DeltaW'(incRep) - DeltaW'(popF) - DeltaW'(decRep);
    endfunction

endpackage

// File: rtl/ras_occupancy.sv
// Occupancy tracker for the return address stack: signed per-cycle delta,
// saturating 0..StackSize count and sticky overflow/underflow flags.
module ras_occupancy
    import ras_predictor_v2_pkg::*;
#(
    parameter int StackSize = 16,
    parameter int CntW      = $clog2(StackSize) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     PushE,
    input  logic                     PopF,
    input  logic                     IncRep,
    input  logic                     DecRep,
    output logic signed [DeltaW-1:0] Delta,
    output logic [CntW-1:0]          Count,
    output logic                     RASOverflow,
    output logic                     RASUnderflow
);

    localparam int SumW = CntW + 1;
    localparam logic signed [SumW-1:0] MaxCnt = SumW'(StackSize);

    logic signed [SumW-1:0] sum;
    logic                   satHigh;
    logic                   satLow;

    assign Delta   = $signed(eventDelta(PushE, IncRep, PopF, DecRep));
    assign sum     = $signed({1'b0, Count}) + SumW'(Delta);
    // Saturation at either rail is what marks an overflow or underflow event.
    assign satHigh = (sum > MaxCnt);
    assign satLow  = sum[SumW-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Count        <= '0;
            RASOverflow  <= 1'b0;
            RASUnderflow <= 1'b0;
        end else begin
            if (satHigh) begin
                Count <= CntW'(StackSize);
            end else if (satLow) begin
                Count <= '0;
            end else begin
                Count <= sum[CntW-1:0];
            end
            RASOverflow  <= RASOverflow | satHigh;
            RASUnderflow <= RASUnderflow | satLow;
        end
    end

endmodule

// File: rtl/ras_predictor_v2.sv
// Return address stack: speculative pop at Fetch, push at Execute on a call
// leaving for Memory, and pointer repair for flushed or misclassified returns.
module ras_predictor_v2
    import ras_predictor_v2_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int StackSize = 16,
    parameter int CntW      = $clog2(StackSize) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            StallD,
    input  logic            StallE,
    input  logic            StallM,
    input  logic            FlushD,
    input  logic            FlushE,
    input  logic            FlushM,
    input  logic            BPReturnF,
    input  logic            BPReturnWrongD,
    input  logic            ReturnD,
    input  logic            ReturnE,
    input  logic            CallE,
    input  logic [XLEN-1:0] PCLinkE,
    output logic [XLEN-1:0] RASPCF,
    output logic            RASValidF,
    output logic            RASOverflow,
    output logic            RASUnderflow
);

    localparam int PtrW = $clog2(StackSize);

    logic                     PopF;
    logic                     PushE;
    logic                     WrongD;
    logic                     FlushedRet;
    logic                     IncRep;
    logic                     DecRep;
    logic signed [DeltaW-1:0] Delta;
    logic [CntW-1:0]          Count;
    logic [PtrW-1:0]          Ptr;
    logic [PtrW-1:0]          NextPtr;
    logic [XLEN-1:0]          mem [StackSize];

    assign PopF       = BPReturnF & ~StallD & ~FlushD;
    assign PushE      = CallE & ~StallM & ~FlushM;
    assign WrongD     = BPReturnWrongD & ~StallE & ~FlushE;
    assign FlushedRet = (~StallE & FlushE & ReturnD) | (FlushM & ReturnE);
    // A flushed return undoes its pop; a wrong "return" undoes a pop, a missed one applies it late.
    assign IncRep     = FlushedRet | (WrongD & ~ReturnD);
    assign DecRep     = WrongD & ReturnD & ~FlushedRet;

    ras_occupancy #(
        .StackSize(StackSize),
        .CntW     (CntW)
    ) occupancy (
        .clk         (clk),
        .reset_n     (reset_n),
        .PushE       (PushE),
        .PopF        (PopF),
        .IncRep      (IncRep),
        .DecRep      (DecRep),
        .Delta       (Delta),
        .Count       (Count),
        .RASOverflow (RASOverflow),
        .RASUnderflow(RASUnderflow)
    );

    // Power-of-two depth makes the pointer wrap naturally in both directions.
    assign NextPtr = Ptr + PtrW'(Delta);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Ptr <= '0;
        end else begin
            Ptr <= NextPtr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < StackSize; i++) begin
                mem[i] <= '0;
            end
        end else if (PushE) begin
            mem[NextPtr] <= PCLinkE;
        end
    end

    assign RASPCF    = mem[Ptr];
    assign RASValidF = (Count != '0);

endmodule

// File: tb/tb_ras_predictor_v2.sv
// Directed plus randomized bench for ras_predictor_v2 (XLEN=32, StackSize=4)
// against an array-based reference stack.
module tb_ras_predictor_v2;

    localparam int XLEN      = 32;
    localparam int StackSize = 4;
    localparam int CntW      = $clog2(StackSize) + 1;

    logic            clk;
    logic            reset_n;
    logic            StallD, StallE, StallM;
    logic            FlushD, FlushE, FlushM;
    logic            BPReturnF, BPReturnWrongD, ReturnD, ReturnE, CallE;
    logic [XLEN-1:0] PCLinkE;
    logic [XLEN-1:0] RASPCF;
    logic            RASValidF, RASOverflow, RASUnderflow;

    int checks;
    int failures;

    // Reference stack state
    logic [XLEN-1:0] mMem [StackSize];
    int              mPtr;
    int              mCnt;
    logic            mOvf;
    logic            mUnf;

    ras_predictor_v2 #(
        .XLEN     (XLEN),
        .StackSize(StackSize),
        .CntW     (CntW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .StallD        (StallD),
        .StallE        (StallE),
        .StallM        (StallM),
        .FlushD        (FlushD),
        .FlushE        (FlushE),
        .FlushM        (FlushM),
        .BPReturnF     (BPReturnF),
        .BPReturnWrongD(BPReturnWrongD),
        .ReturnD       (ReturnD),
        .ReturnE       (ReturnE),
        .CallE         (CallE),
        .PCLinkE       (PCLinkE),
        .RASPCF        (RASPCF),
        .RASValidF     (RASValidF),
        .RASOverflow   (RASOverflow),
        .RASUnderflow  (RASUnderflow)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    RASPCF, mMem[mPtr]);
        check({tag, ".valid"}, 32'(RASValidF), 32'(mCnt != 0));
        check({tag, ".ovf"},   32'(RASOverflow), 32'(mOvf));
        check({tag, ".unf"},   32'(RASUnderflow), 32'(mUnf));
        check({tag, ".cnt"},   32'(dut.Count), 32'(mCnt));
        check({tag, ".ptr"},   32'(dut.Ptr), 32'(mPtr));
    endtask

    task automatic clear_inputs();
        StallD = 0; StallE = 0; StallM = 0;
        FlushD = 0; FlushE = 0; FlushM = 0;
        BPReturnF = 0; BPReturnWrongD = 0; ReturnD = 0; ReturnE = 0; CallE = 0;
        PCLinkE = '0;
    endtask

    // Reference: apply one cycle of stack events straight from the behavioural rules.
    task automatic model_cycle();
        int popF, pushE, wrongD, flushedRet, incRep, decRep, delta, c;
        popF       = int'(BPReturnF && !StallD && !FlushD);
        pushE      = int'(CallE && !StallM && !FlushM);
        wrongD     = int'(BPReturnWrongD && !StallE && !FlushE);
        flushedRet = int'((!StallE && FlushE && ReturnD) || (FlushM && ReturnE));
        incRep     = int'(flushedRet != 0 || (wrongD != 0 && !ReturnD));
        decRep     = int'(wrongD != 0 && ReturnD && flushedRet == 0);
        delta      = pushE + incRep - popF - decRep;
        mPtr       = ((mPtr + delta) % StackSize + StackSize) % StackSize;
        if (pushE != 0) mMem[mPtr] = PCLinkE;
        c = mCnt + delta;
        if (c > StackSize) begin c = StackSize; mOvf = 1'b1; end
        if (c < 0)         begin c = 0;         mUnf = 1'b1; end
        mCnt = c;
    endtask

    // Inputs are already driven; confirm no combinational leak, then clock and compare.
    task automatic cycle(input string tag);
        check({tag, ".pre"}, RASPCF, mMem[mPtr]);
        model_cycle();
        @(posedge clk);
        #1;
        check_all(tag);
        clear_inputs();
    endtask

    task automatic push(input logic [31:0] link, input string tag);
        CallE = 1; PCLinkE = link;
        cycle(tag);
    endtask

    task automatic pop(input string tag);
        BPReturnF = 1;
        cycle(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 0; BPReturnF = 1; CallE = 1; PCLinkE = $urandom;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < StackSize; i++) mMem[i] = '0;
        mPtr = 0; mCnt = 0; mOvf = 0; mUnf = 0;
        check_all(tag);
        reset_n = 1;
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clear_inputs();
        reset_n = 0;
        for (int i = 0; i < StackSize; i++) mMem[i] = '0;
        mPtr = 0; mCnt = 0; mOvf = 0; mUnf = 0;
        #2;

        // Reset dominates pushes and pops
        do_reset("reset");
        check("reset.pc_zero", RASPCF, 32'h0);

        // Push sequence then one pop
        push(32'h100, "push1");
        push(32'h200, "push2");
        push(32'h300, "push3");
        check("push3.top", RASPCF, 32'h300);
        check("push3.count", 32'(dut.Count), 32'd3);
        pop("pop1");
        check("pop1.top", RASPCF, 32'h200);
        check("pop1.count", 32'(dut.Count), 32'd2);

        // Overflow with five pushes, then drain
        do_reset("reset_ovf");
        for (int i = 1; i <= 5; i++) push(32'(i * 32'h100), "ovf_push");
        check("ovf.flag", 32'(RASOverflow), 32'd1);
        check("ovf.count", 32'(dut.Count), 32'd4);
        check("ovf.top", RASPCF, 32'h500);
        pop("ovf_pop1"); check("ovf_pop1.top", RASPCF, 32'h400);
        pop("ovf_pop2"); check("ovf_pop2.top", RASPCF, 32'h300);
        pop("ovf_pop3"); check("ovf_pop3.top", RASPCF, 32'h200);
        pop("ovf_pop4");
        check("ovf_pop4.valid", 32'(RASValidF), 32'd0);
        check("ovf_pop4.count", 32'(dut.Count), 32'd0);

        // Underflow from empty
        do_reset("reset_unf");
        pop("unf_pop");
        check("unf.flag", 32'(RASUnderflow), 32'd1);
        check("unf.ptr", 32'(dut.Ptr), 32'd3);
        check("unf.count", 32'(dut.Count), 32'd0);

        // Simultaneous push and pop replaces the top
        do_reset("reset_pp");
        push(32'h100, "pp_push1");
        push(32'h200, "pp_push2");
        push(32'h300, "pp_push3");
        BPReturnF = 1; CallE = 1; PCLinkE = 32'h700;
        cycle("pp_both");
        check("pp.top", RASPCF, 32'h700);
        check("pp.ptr", 32'(dut.Ptr), 32'd3);
        check("pp.count", 32'(dut.Count), 32'd3);

        // Repair: flushed pop restores, missed return decrements, repair plus push gives +2
        pop("rep_pop");
        check("rep_pop.top", RASPCF, 32'h200);
        FlushE = 1; ReturnD = 1;
        cycle("rep_flush");
        check("rep_flush.top", RASPCF, 32'h700);
        check("rep_flush.count", 32'(dut.Count), 32'd3);
        BPReturnWrongD = 1; ReturnD = 1;
        cycle("rep_missed");
        check("rep_missed.ptr", 32'(dut.Ptr), 32'd2);
        check("rep_missed.top", RASPCF, 32'h200);
        BPReturnWrongD = 1; ReturnD = 0; CallE = 1; PCLinkE = 32'h800;
        cycle("rep_plus2");
        check("rep_plus2.ptr", 32'(dut.Ptr), 32'd0);
        check("rep_plus2.top", RASPCF, 32'h800);
        check("rep_plus2.count", 32'(dut.Count), 32'd4);
        FlushM = 1; ReturnE = 1;
        cycle("rep_flushm");

        // Randomized traffic, occasional mid-run reset
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_reset");
            end else begin
                BPReturnF      = ($urandom_range(0, 2) == 0);
                CallE          = ($urandom_range(0, 2) == 0);
                PCLinkE        = $urandom;
                BPReturnWrongD = ($urandom_range(0, 5) == 0);
                ReturnD        = ($urandom_range(0, 2) == 0);
                ReturnE        = ($urandom_range(0, 2) == 0);
                StallD         = ($urandom_range(0, 5) == 0);
                StallE         = ($urandom_range(0, 5) == 0);
                StallM         = ($urandom_range(0, 5) == 0);
                FlushD         = ($urandom_range(0, 7) == 0);
                FlushE         = ($urandom_range(0, 7) == 0);
                FlushM         = ($urandom_range(0, 7) == 0);
                cycle("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
